// File: rtl/fsm_run_detector.sv
// fsm_run_detector: Moore run detector over the symbol MSB class with a saturating event counter; define FSM_RUN_STICKY_EN to enable sticky class transfer
module fsm_run_detector #(
  parameter int W = 2,
  parameter int RUN_LEN = 2,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [W-1:0]     i_data,
  output logic             o_detect,
  output logic             o_class,
  output logic [LW-1:0]    o_run_len,
  output logic [CNT_W-1:0] o_event_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DET = 2'd2} state_t;
  localparam logic [LW-1:0] FULL = LW'(RUN_LEN);
  state_t state, nxt_state;
  logic cls, in_run, sticky, unused_bits;
  logic [LW-1:0] nxt_len;
  assign unused_bits = ^i_data;
  assign o_detect = (state == DET);
  // run length and next state a valid sample would produce
  always_comb begin
    cls = i_data[W-1];
    in_run = (state == RUN) || (state == DET);
`ifdef FSM_RUN_STICKY_EN
    sticky = (state == DET) && (cls != o_class) && i_data[0];
`else
    sticky = 1'b0;
`endif
    nxt_len = sticky ? FULL : (in_run && cls == o_class) ? ((o_run_len >= FULL) ? FULL : o_run_len + 1'b1) : LW'(1);
    nxt_state = (nxt_len >= FULL) ? DET : RUN;
  end
  // state, run tracking and saturating count of DET entries
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      o_class <= 1'b0;
      o_run_len <= '0;
      o_event_cnt <= '0;
    end else if (i_clear) begin
      state <= IDLE;
      o_class <= 1'b0;
      o_run_len <= '0;
      o_event_cnt <= '0;
    end else if (!in_run && state != IDLE) begin
      state <= IDLE;
    end else if (i_valid) begin
      state <= nxt_state;
      o_class <= cls;
      o_run_len <= nxt_len;
      if (nxt_state == DET && state != DET && !(&o_event_cnt))
        o_event_cnt <= o_event_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fsm_run_detector.sv
// tb_fsm_run_detector: table-driven scoreboard bench for fsm_run_detector (default and saturating configurations)
module tb_fsm_run_detector;
`ifdef FSM_RUN_STICKY_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic c1 = 1'b0, v1 = 1'b0, c2 = 1'b0, v2 = 1'b0;
  logic [1:0] d1 = 2'd0, d2 = 2'd0;
  logic det1, cls1, det2, cls2;
  logic [1:0] len1, len2, cnt2;
  logic [7:0] cnt1;
  int checks = 0, errors = 0;
  logic [11:0] exp_q[$];
  typedef struct {
    logic clr;
    logic vld;
    logic [1:0] d;
    logic [11:0] e;
  } vec_t;
  vec_t tbl[$];

  fsm_run_detector u1 (.clk(clk), .rstn(rstn), .i_clear(c1), .i_valid(v1), .i_data(d1),
    .o_detect(det1), .o_class(cls1), .o_run_len(len1), .o_event_cnt(cnt1));
  fsm_run_detector #(.W(2), .RUN_LEN(3), .CNT_W(2)) u2 (.clk(clk), .rstn(rstn), .i_clear(c2), .i_valid(v2), .i_data(d2),
    .o_detect(det2), .o_class(cls2), .o_run_len(len2), .o_event_cnt(cnt2));

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input logic det, input logic cls, input logic [1:0] len, input logic [7:0] cnt);
    return {det, cls, len, cnt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got det=%0b cls=%0b len=%0d cnt=%0d, want det=%0b cls=%0b len=%0d cnt=%0d",
        name, act[11], act[10], act[9:8], act[7:0], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic step(input int u, input logic clr, input logic vld, input logic [1:0] d, input logic [11:0] e, input string name);
    logic [11:0] ex;
    @(negedge clk);
    if (u == 1) begin c1 = clr; v1 = vld; d1 = d; end
    else begin c2 = clr; v2 = vld; d2 = d; end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      ex = exp_q.pop_front();
      check(name, (u == 1) ? pk(det1, cls1, len1, cnt1) : pk(det2, cls2, len2, {6'd0, cnt2}), ex);
    end
    c1 = 1'b0; v1 = 1'b0; c2 = 1'b0; v2 = 1'b0;
  endtask

  task automatic add(input logic clr, input logic vld, input logic [1:0] d, input logic det, input logic cls, input logic [1:0] len, input logic [7:0] cnt);
    vec_t v;
    v.clr = clr; v.vld = vld; v.d = d; v.e = pk(det, cls, len, cnt);
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add(0, 1, 2'b00, 0, 0, 1, 0);
    add(0, 1, 2'b01, 1, 0, 2, 1);
    add(0, 0, 2'b11, 1, 0, 2, 1);
    add(0, 1, 2'b10, 0, 1, 1, 1);
    add(0, 0, 2'b00, 0, 1, 1, 1);
    add(0, 0, 2'b01, 0, 1, 1, 1);
    add(0, 0, 2'b00, 0, 1, 1, 1);
    add(0, 1, 2'b11, 1, 1, 2, 2);
    add(0, 1, 2'b11, 1, 1, 2, 2);
    add(1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 1, 2'b00, 0, 0, 1, 0);
    add(0, 1, 2'b01, 1, 0, 2, 1);
    add(0, 1, 2'b11, S, 1, S ? 2'd2 : 2'd1, 1);
    add(0, 1, 2'b10, 1, 1, 2, S ? 8'd1 : 8'd2);
    add(0, 1, 2'b00, 0, 0, 1, S ? 8'd1 : 8'd2);
    add(0, 1, 2'b00, 1, 0, 2, S ? 8'd2 : 8'd3);
    add(1, 1, 2'b00, 0, 0, 0, 0);
    add(0, 1, 2'b01, 0, 0, 1, 0);
    add(0, 1, 2'b11, 0, 1, 1, 0);
    add(0, 1, 2'b10, 1, 1, 2, 1);
    #12;
    check("reset_u1", pk(det1, cls1, len1, cnt1), 12'd0);
    check("reset_u2", pk(det2, cls2, len2, {6'd0, cnt2}), 12'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < tbl.size(); i++)
      step(1, tbl[i].clr, tbl[i].vld, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
    step(1, 0, 1, 2'b00, pk(0, 0, 1, 1), "pre_reset");
    rstn = 1'b0;
    #2;
    check("async_reset", pk(det1, cls1, len1, cnt1), 12'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1, 0, 1, 2'b10, pk(0, 1, 1, 0), "post_reset_first");
    step(1, 0, 1, 2'b11, pk(1, 1, 2, 1), "post_reset_det");
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++)
        step(2, 0, 1, {k[0], 1'b0},
          pk(j == 2, k[0], 2'(j + 1), (j == 2) ? 8'((k + 1 > 3) ? 3 : k + 1) : 8'((k > 3) ? 3 : k)),
          $sformatf("sat_run%0d_s%0d", k, j));
    step(2, 0, 1, 2'b00, pk(1, 0, 3, 3), "sat_len_cap");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fsm_run_detector.md
# fsm_run_detector

Parametrised Moore-type run detector for the FSM block family. It watches a stream of W-bit symbols qualified by a valid strobe and classifies each symbol by its MSB. It asserts a registered detect flag once RUN_LEN consecutive valid symbols share the same class, and counts detection events. An optional sticky mode lets a qualifying symbol carry an active detection across a class change.

## Interface
- W, default 2: symbol width; legal W >= 1.
- RUN_LEN, default 2: consecutive same-class valid symbols needed for detection; legal 1..255.
- CNT_W, default 8: event counter width; legal CNT_W >= 1.
- LW, localparam: $clog2(RUN_LEN+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- i_clear  in  1  synchronous clear; returns to IDLE and zeroes the counter; has priority over i_valid.
- i_valid  in  1  i_data is sampled on this cycle.
- i_data  in  W  symbol; class = i_data[W-1], sticky qualifier = i_data[0].
- o_detect  out  1  high while the state is DET (Moore).
- o_class  out  1  class of the current run.
- o_run_len  out  LW  current run length, saturating at RUN_LEN.
- o_event_cnt  out  CNT_W  count of entries into DET, saturating at all-ones.

## Operation
- State register values: IDLE, RUN, DET. Registers r_class and r_len.
- Reset (rstn low, asynchronous): state IDLE, o_detect 0, o_class 0, o_run_len 0, o_event_cnt 0.
- i_clear high: same values as reset, applied at the next edge, regardless of i_valid.
- i_valid low and no clear: all state holds.
- Valid sample, class c, from IDLE: r_class = c, r_len = 1. State becomes DET if RUN_LEN == 1, otherwise RUN.
- Valid sample in RUN or DET with c == r_class: r_len = min(r_len+1, RUN_LEN). State becomes DET when the new length is >= RUN_LEN, otherwise it stays RUN.
- Valid sample in RUN or DET with c != r_class:
  - If sticky mode is enabled, the state is DET and i_data[0] == 1: state stays DET, r_class = c, r_len = RUN_LEN.
  - Otherwise: r_class = c, r_len = 1. State becomes DET if RUN_LEN == 1, otherwise RUN.
- Event counter: increments by 1 on every edge where the state goes from non-DET to DET.
  - A sticky class transfer does not increment it.
  - Staying in DET does not increment it.
  - It saturates at 2^CNT_W-1 and never wraps.
- Illegal state encoding: recovers to IDLE on the next edge. o_detect is 0 while the encoding is illegal.
- W == 1: the sticky qualifier equals the class bit, so only a change into class 1 can be sticky.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: the sample that completes a run is taken at edge N, and o_detect is high after edge N.
- o_detect drops after the edge that samples the breaking symbol.
- o_class and o_run_len update on the same edge as the state.
- With RUN_LEN == 1, every valid sample produces DET one cycle later. The counter increments only on the first such sample after IDLE/RUN.
- Simultaneous i_clear and i_valid: clear wins and the sample is discarded.
- Reset asserted mid-run: outputs clear immediately (asynchronous). The first sample after reset release starts a new run of length 1.

## Configuration
- FSM_RUN_STICKY_EN defined: the sticky class-transfer rule above is active.
- FSM_RUN_STICKY_EN undefined: any class change restarts the run at length 1, and the sticky logic is compiled out.

## Test plan
- Reset check: defaults, hold rstn low, then release. All outputs must be 0. Then send valid 00, 01. o_detect rises one cycle after the 01 sample, o_class = 0, o_event_cnt = 1.
- Valid gaps: send 10, then i_valid low for 3 cycles, then 11. The gap does not break the run. o_detect rises after the 11 sample, o_class = 1, o_run_len = 2.
- Sticky transfer, with the macro defined: 00, 01, 11. o_detect stays high through the 11 sample, o_class goes to 1, o_event_cnt stays 1. Then 10 keeps DET. Then 00 drops o_detect, o_run_len = 1.
- Sticky compiled out: 00, 01, 11. o_detect drops, o_run_len = 1. Then 10 re-enters DET and o_event_cnt = 2.
- Counter saturation: CNT_W=2, RUN_LEN=3. Drive five alternating-class runs of three symbols. o_event_cnt reads 1, 2, 3, 3, 3. o_run_len never exceeds 3.
- Clear priority: mid-run, assert i_clear together with i_valid and a same-class symbol. The next cycle shows state IDLE, all outputs 0, and the sample is ignored.
